// File: rtl/bitrev_pkg.sv
// Shared types and defaults for the bit-reversal reorder buffer.
// Optional last_o output is enabled by defining BITREV_LAST_EN.
package bitrev_pkg;

    localparam int K_MAX_DEF = 10;
    localparam int K_MIN_DEF = 3;
    localparam int KW_DEF    = $clog2(K_MAX_DEF + 1);

    typedef logic [KW_DEF-1:0] k_t;
    typedef logic              bank_t;

    function automatic int unsigned frame_len(k_t k);
        return 32'd1 << k;
    endfunction

endpackage

// File: rtl/bitrev_addr_rev.sv
// Reverses the low k bits of an address: full reverse, then right
// shift by (K_MAX-k). Upper address bits must already be zero.
module bitrev_addr_rev
    import bitrev_pkg::*;
#(
    parameter int K_MAX = K_MAX_DEF,
    parameter int KW    = $clog2(K_MAX + 1)
) (
    input  logic [K_MAX-1:0] addr_i,
    input  logic [KW-1:0]    k_i,
    output logic [K_MAX-1:0] rev_o
);

    logic [K_MAX-1:0] full_rev;

    always_comb begin
        full_rev = '0;
        for (int i = 0; i < K_MAX; i++) begin
            full_rev[i] = addr_i[K_MAX-1-i];
        end
        rev_o = full_rev >> (KW'(K_MAX) - k_i);
    end

endmodule

// File: rtl/bitrev_reorder.sv
// Ping-pong bit-reversal reorder buffer with runtime frame size,
// per-frame bypass and valid/ready on both sides (last_o: BITREV_LAST_EN).
module bitrev_reorder
    import bitrev_pkg::*;
#(
    parameter int K_MAX    = K_MAX_DEF,
    parameter int K_MIN    = K_MIN_DEF,
    parameter int DW       = 32,
    localparam int KW      = $clog2(K_MAX + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [KW-1:0] cfg_k_i,
    input  logic          cfg_bypass_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    input  logic          ready_i
`ifdef BITREV_LAST_EN
    ,
    output logic          last_o
`endif
);

    localparam int DEPTH = 1 << K_MAX;

    logic [DW-1:0]         mem_q [2*DEPTH];

    logic [1:0]            full_q, full_d;
    logic [1:0]            bank_byp_q, bank_byp_d;
    logic [1:0][KW-1:0]    bank_k_q, bank_k_d;
    bank_t                 wr_bank_q, wr_bank_d;
    bank_t                 rd_bank_q, rd_bank_d;
    logic [K_MAX-1:0]      wr_cnt_q, wr_cnt_d;
    logic [K_MAX-1:0]      rd_cnt_q, rd_cnt_d;
    logic                  valid_q, valid_d;
    logic [DW-1:0]         data_q, data_d;
`ifdef BITREV_LAST_EN
    logic                  last_q, last_d;
`endif

    logic [KW-1:0]         k_eff;
    logic [KW-1:0]         wr_k;
    logic [KW-1:0]         rd_k;
    logic                  wr_fire;
    logic                  wr_last;
    logic                  rd_load;
    logic                  rd_last;
    logic [K_MAX-1:0]      rd_rev;
    logic [K_MAX-1:0]      rd_addr;

    assign ready_o = !full_q[wr_bank_q];
    assign wr_fire = valid_i && ready_o;

    // Out-of-range sizes fall back to the largest frame.
    assign k_eff = (cfg_k_i < KW'(K_MIN) || cfg_k_i > KW'(K_MAX))
                 ? KW'(K_MAX) : cfg_k_i;
    assign wr_k  = (wr_cnt_q == '0) ? k_eff : bank_k_q[wr_bank_q];
    assign wr_last = (32'(wr_cnt_q) == frame_len(k_t'(wr_k)) - 1);

    assign rd_k    = bank_k_q[rd_bank_q];
    assign rd_load = full_q[rd_bank_q] && (ready_i || !valid_q);
    assign rd_last = (32'(rd_cnt_q) == frame_len(k_t'(rd_k)) - 1);

    bitrev_addr_rev #(
        .K_MAX (K_MAX),
        .KW    (KW)
    ) u_addr_rev (
        .addr_i (rd_cnt_q),
        .k_i    (rd_k),
        .rev_o  (rd_rev)
    );

    assign rd_addr = bank_byp_q[rd_bank_q] ? rd_cnt_q : rd_rev;

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[{wr_bank_q, wr_cnt_q}] <= data_i;
        end
    end

    always_comb begin
        full_d     = full_q;
        bank_byp_d = bank_byp_q;
        bank_k_d   = bank_k_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        valid_d    = valid_q;
        data_d     = data_q;
`ifdef BITREV_LAST_EN
        last_d     = last_q;
`endif
        if (wr_fire) begin
            if (wr_cnt_q == '0) begin
                bank_k_d[wr_bank_q]   = k_eff;
                bank_byp_d[wr_bank_q] = cfg_bypass_i;
            end
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_cnt_d          = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
        if (rd_load) begin
            valid_d = 1'b1;
            data_d  = mem_q[{rd_bank_q, rd_addr}];
`ifdef BITREV_LAST_EN
            last_d  = rd_last;
`endif
            if (rd_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
                rd_cnt_d          = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end else if (ready_i) begin
            valid_d = 1'b0;
`ifdef BITREV_LAST_EN
            last_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q     <= '0;
            bank_byp_q <= '0;
            bank_k_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
`ifdef BITREV_LAST_EN
            last_q     <= 1'b0;
`endif
        end else begin
            full_q     <= full_d;
            bank_byp_q <= bank_byp_d;
            bank_k_q   <= bank_k_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
`ifdef BITREV_LAST_EN
            last_q     <= last_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
`ifdef BITREV_LAST_EN
    assign last_o  = last_q;
`endif

endmodule
